// File: rtl/lt100_pkg.sv
// Shared types for the lt100 prefetch buffer: FSM states, FIFO entry layout and bus constants.
package lt100_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PF_WAIT = 2'd1,
    ST_D_WAIT  = 2'd2,
    ST_GAP     = 2'd3
  } pf_state_e;

  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
    logic        err;
  } pf_entry_t;

endpackage

// File: rtl/lt100_pf_fifo.sv
// Prefetch FIFO: synchronous push/pop with flush, head peek, full and empty flags.
module lt100_pf_fifo
  import lt100_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_flush,
  input  logic      i_push,
  input  pf_entry_t i_push_data,
  input  logic      i_pop,
  output pf_entry_t o_head,
  output logic      o_full,
  output logic      o_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = (PW + 1)'(1);

  pf_entry_t   r_mem [DEPTH];
  logic [PW:0] r_wr_ptr;
  logic [PW:0] r_rd_ptr;
  logic        w_do_push;
  logic        w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                     (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign o_head    = r_mem[r_rd_ptr[PW-1:0]];
  assign w_do_pop  = i_pop && !o_empty && !i_flush;
  // A pop frees the slot the push lands in, so push-on-full is legal when paired with a pop.
  assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[PW-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/lt100_prefetch.sv
// Instruction prefetch buffer and bus arbiter for lt100. Optional LT100_PF_STORE_FLUSH_EN:
// granted stores flush the prefetch FIFO to keep self-modifying code coherent.
module lt100_prefetch
  import lt100_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_en,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_data,
  output logic        if_err,
  input  logic        d_en,
  input  logic        d_wr_en,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        bus_enable,
  output logic        bus_wr_en,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_i_data,
  output logic [3:0]  bus_be,
  input  logic        bus_ready,
  input  logic [31:0] bus_o_data,
  input  logic        bus_err
);
  pf_state_e   r_state, w_state_nxt;
  logic [29:0] r_pf_addr, w_pf_addr_nxt;
  logic        r_drop, w_drop_nxt;
  logic        r_err_halt, w_err_halt_nxt;
  logic        r_if_ready, r_if_err, r_d_ready, r_d_err;
  logic [31:0] r_if_data, r_d_rdata;
  logic        r_bus_enable, r_bus_wr_en;
  logic [31:0] r_bus_addr, r_bus_i_data;
  logic [3:0]  r_bus_be;
  pf_entry_t   w_head, w_push_data;
  logic        w_full, w_empty, w_push, w_flush, w_store_flush;
  logic        w_if_req, w_d_req, w_head_match, w_waiting, w_hit, w_miss;
  logic        w_issue_pf, w_issue_d;
  logic [1:0]  w_unused_if_lo;

  assign w_unused_if_lo = if_addr[1:0];

  // The core drops *_en one cycle late, so requests are masked while the ready pulse is out.
  assign w_if_req     = if_en && !r_if_ready;
  assign w_d_req      = d_en && !r_d_ready;
  assign w_head_match = !w_empty && (w_head.addr == if_addr[31:2]);
  // An empty FIFO already aimed at the requested word is a pending miss, not a new one.
  assign w_waiting    = w_empty && !r_err_halt && (r_pf_addr == if_addr[31:2]);
  assign w_hit        = w_if_req && w_head_match;
  assign w_miss       = w_if_req && !w_head_match && !w_waiting;

`ifdef LT100_PF_STORE_FLUSH_EN
  assign w_store_flush = (r_state == ST_IDLE) && w_d_req && d_wr_en;
`else
  assign w_store_flush = 1'b0;
`endif
  assign w_flush     = w_miss || w_store_flush;
  assign w_push_data = '{addr: r_pf_addr, data: bus_o_data, err: bus_err};

  lt100_pf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (w_flush),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_hit),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_pf_addr_nxt  = r_pf_addr;
    w_drop_nxt     = r_drop;
    w_err_halt_nxt = r_err_halt;
    w_push         = 1'b0;
    w_issue_pf     = 1'b0;
    w_issue_d      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_d_req) begin
          w_issue_d   = 1'b1;
          w_state_nxt = ST_D_WAIT;
        end else if (!w_full && !r_err_halt && !w_flush) begin
          w_issue_pf  = 1'b1;
          w_state_nxt = ST_PF_WAIT;
        end
      end
      ST_PF_WAIT: begin
        if (bus_ready) begin
          w_state_nxt = ST_GAP;
          w_drop_nxt  = 1'b0;
          if (!r_drop && !w_flush) begin
            w_push        = 1'b1;
            w_pf_addr_nxt = r_pf_addr + 30'd1;
            if (bus_err) w_err_halt_nxt = 1'b1;
          end
        end
      end
      ST_D_WAIT: if (bus_ready) w_state_nxt = ST_GAP;
      ST_GAP:    w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
    if (w_miss) begin
      w_pf_addr_nxt  = if_addr[31:2];
      w_err_halt_nxt = 1'b0;
      if (r_state == ST_PF_WAIT && !bus_ready) w_drop_nxt = 1'b1;
    end else if (w_store_flush) begin
      w_err_halt_nxt = 1'b0;
      // Restart from the oldest word the core has not yet consumed.
      if (!w_empty) w_pf_addr_nxt = w_hit ? w_head.addr + 30'd1 : w_head.addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_pf_addr    <= '0;
      r_drop       <= 1'b0;
      r_err_halt   <= 1'b0;
      r_if_ready   <= 1'b0;
      r_if_data    <= '0;
      r_if_err     <= 1'b0;
      r_d_ready    <= 1'b0;
      r_d_rdata    <= '0;
      r_d_err      <= 1'b0;
      r_bus_enable <= 1'b0;
      r_bus_wr_en  <= 1'b0;
      r_bus_addr   <= '0;
      r_bus_i_data <= '0;
      r_bus_be     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pf_addr  <= w_pf_addr_nxt;
      r_drop     <= w_drop_nxt;
      r_err_halt <= w_err_halt_nxt;
      r_if_ready <= w_hit;
      if (w_hit) begin
        r_if_data <= w_head.data;
        r_if_err  <= w_head.err;
      end
      r_d_ready <= (r_state == ST_D_WAIT) && bus_ready;
      if ((r_state == ST_D_WAIT) && bus_ready) begin
        r_d_rdata <= bus_o_data;
        r_d_err   <= bus_err;
      end
      if (w_issue_d) begin
        r_bus_enable <= 1'b1;
        r_bus_wr_en  <= d_wr_en;
        r_bus_addr   <= d_addr;
        r_bus_i_data <= d_wdata;
        r_bus_be     <= d_be;
      end else if (w_issue_pf) begin
        r_bus_enable <= 1'b1;
        r_bus_wr_en  <= 1'b0;
        r_bus_addr   <= {r_pf_addr, 2'b00};
        r_bus_i_data <= '0;
        r_bus_be     <= BE_WORD;
      end else if (bus_ready && (r_state == ST_PF_WAIT || r_state == ST_D_WAIT)) begin
        r_bus_enable <= 1'b0;
      end
    end
  end

  assign if_ready   = r_if_ready;
  assign if_data    = r_if_data;
  assign if_err     = r_if_err;
  assign d_ready    = r_d_ready;
  assign d_rdata    = r_d_rdata;
  assign d_err      = r_d_err;
  assign bus_enable = r_bus_enable;
  assign bus_wr_en  = r_bus_wr_en;
  assign bus_addr   = r_bus_addr;
  assign bus_i_data = r_bus_i_data;
  assign bus_be     = r_bus_be;

endmodule

// File: tb/tb_lt100_prefetch.sv
// Self-checking bench for lt100_prefetch: directed scenarios, then randomized fetch/data traffic
// against a word-addressed memory reference and a bus with programmable latency.
module tb_lt100_prefetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_en = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ready, if_err;
  logic [31:0] if_data;
  logic        d_en = 1'b0, d_wr_en = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic [3:0]  d_be = '0;
  logic        d_ready, d_err;
  logic [31:0] d_rdata;
  logic        bus_enable, bus_wr_en;
  logic [31:0] bus_addr, bus_i_data;
  logic [3:0]  bus_be;
  logic        bus_ready = 1'b0, bus_err = 1'b0;
  logic [31:0] bus_o_data = '0;

  int          errors = 0;
  int          checks = 0;
  int          lat = 2;
  logic [31:0] err_addr = 32'h7FFF_0000;
  logic [31:0] bus_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [32:0] log_q [$];

  lt100_prefetch #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_en(if_en), .if_addr(if_addr), .if_ready(if_ready), .if_data(if_data), .if_err(if_err),
    .d_en(d_en), .d_wr_en(d_wr_en), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
    .bus_enable(bus_enable), .bus_wr_en(bus_wr_en), .bus_addr(bus_addr),
    .bus_i_data(bus_i_data), .bus_be(bus_be),
    .bus_ready(bus_ready), .bus_o_data(bus_o_data), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_3C3C;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  function automatic logic [32:0] log_at(input int k);
    if (k < log_q.size()) return log_q[k];
    return '1;
  endfunction

  function automatic logic log_has(input logic [31:0] a);
    foreach (log_q[i]) if (log_q[i] == {1'b0, a}) return 1'b1;
    return 1'b0;
  endfunction

  // Bus slave: bus_ready on the lat-th cycle of bus_enable; every completed access is logged.
  initial begin : bus_model
    int cnt;
    logic [31:0] a;
    cnt = 0;
    forever begin
      @(negedge clk);
      bus_ready = 1'b0;
      bus_err   = 1'b0;
      if (!rst_n) begin
        cnt = 0;
      end else if (bus_enable) begin
        cnt++;
        if (cnt >= lat) begin
          cnt = 0;
          a = {bus_addr[31:2], 2'b00};
          log_q.push_back({bus_wr_en, a});
          bus_ready = 1'b1;
          if (bus_wr_en) begin
            bus_mem[a] = bus_i_data;
          end else begin
            bus_o_data = bus_mem.exists(a) ? bus_mem[a] : init_word(a);
            bus_err    = (a == err_addr);
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fetch(input logic [31:0] a, output logic [31:0] data, output logic err,
                       output int cyc);
    if_addr = a;
    if_en   = 1'b1;
    cyc     = 0;
    data    = '0;
    err     = 1'b0;
    while (1) begin
      @(posedge clk);
      #1;
      cyc++;
      if (if_ready) begin
        data = if_data;
        err  = if_err;
        break;
      end
      if (cyc >= 300) begin
        check("fetch_timeout", 64'(if_ready), 64'(1));
        break;
      end
    end
    if_en = 1'b0;
  endtask

  task automatic fetch_chk(input string tag, input logic [31:0] a, input int exp_lat);
    logic [31:0] d;
    logic        e;
    int          c;
    fetch(a, d, e, c);
    check({tag, "_data"}, 64'(d), 64'(ref_rd(a)));
    check({tag, "_err"}, 64'(e), 64'(a == err_addr));
    if (exp_lat > 0) check({tag, "_lat"}, 64'(c), 64'(exp_lat));
    idle(1);
  endtask

  task automatic daccess(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output int cyc);
    d_en    = 1'b1;
    d_wr_en = wr;
    d_addr  = a;
    d_wdata = wd;
    d_be    = 4'hF;
    cyc     = 0;
    rd      = '0;
    er      = 1'b0;
    while (1) begin
      @(posedge clk);
      #1;
      cyc++;
      if (d_ready) begin
        rd = d_rdata;
        er = d_err;
        break;
      end
      if (cyc >= 300) begin
        check("data_timeout", 64'(d_ready), 64'(1));
        break;
      end
    end
    d_en    = 1'b0;
    d_wr_en = 1'b0;
  endtask

  task automatic dread_chk(input string tag, input logic [31:0] a, input int exp_lat);
    logic [31:0] rd;
    logic        er;
    int          c;
    daccess(1'b0, a, 32'h0, rd, er, c);
    check({tag, "_data"}, 64'(rd), 64'(ref_rd(a)));
    check({tag, "_err"}, 64'(er), 64'(0));
    if (exp_lat > 0) check({tag, "_lat"}, 64'(c), 64'(exp_lat));
    idle(1);
  endtask

  task automatic dwrite(input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] rd;
    logic        er;
    int          c;
    daccess(1'b1, a, wd, rd, er, c);
    ref_mem[a] = wd;
    check("dwrite_err", 64'(er), 64'(0));
    idle(1);
  endtask

  task automatic wait_bus_enable(input string tag);
    for (int i = 0; i < 100; i++) begin
      if (bus_enable) break;
      @(posedge clk);
      #1;
    end
    check(tag, 64'(bus_enable), 64'(1));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: observed=no end of test, required=end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [31:0] pc;
    logic [31:0] a;
    int          r;

    // Reset state
    idle(3);
    check("rst_if_ready", 64'(if_ready), 64'(0));
    check("rst_if_data", 64'(if_data), 64'(0));
    check("rst_d_ready", 64'(d_ready), 64'(0));
    check("rst_bus_enable", 64'(bus_enable), 64'(0));
    rst_n = 1'b1;
    log_q.delete();

    // First fetch after reset, then sequential hits
    lat = 2;
    fetch_chk("t1_a0", 32'h0, 0);
    check("t1_first_bus", 64'(log_at(0)), 64'({1'b0, 32'h0}));
    idle(12);
    fetch_chk("t1_a4", 32'h4, 1);
    fetch_chk("t1_a8", 32'h8, 1);
    fetch_chk("t1_aC", 32'hC, 1);

    // Full FIFO at 0x10-0x1C stops prefetch; a jump flushes and refetches
    idle(20);
    check("t2_stop_at_full", 64'(log_q[$]), 64'({1'b0, 32'h1C}));
    log_q.delete();
    fetch_chk("t2_jump", 32'h100, 5);
    check("t2_jump_bus", 64'(log_at(0)), 64'({1'b0, 32'h100}));

    // Data read while a prefetch is in flight
    lat = 6;
    fetch_chk("t3_miss", 32'h200, 0);
    wait_bus_enable("t3_pf_inflight");
    check("t3_pf_be", 64'(bus_be), 64'(4'hF));
    check("t3_pf_wr", 64'(bus_wr_en), 64'(0));
    log_q.delete();
    dread_chk("t3_dread", 32'h2000, 0);
    check("t3_order0", 64'(log_at(0)), 64'({1'b0, 32'h204}));
    check("t3_order1", 64'(log_at(1)), 64'({1'b0, 32'h2000}));
    fetch_chk("t3_hit", 32'h204, 1);
    idle(60);
    dread_chk("t3_didle", 32'h2100, 7);
    dwrite(32'h3000, 32'hDEAD_BEEF);
    dread_chk("t3_wr_rd", 32'h3000, 0);

    // Bus error entry halts prefetch until the next flush
    lat = 2;
    err_addr = 32'h8;
    fetch_chk("t4_a0", 32'h0, 0);
    idle(20);
    fetch_chk("t4_a4", 32'h4, 1);
    fetch_chk("t4_a8", 32'h8, 1);
    check("t4_halted", 64'(log_has(32'hC)), 64'(0));
    err_addr = 32'h7FFF_0000;
    fetch_chk("t4_aC", 32'hC, 0);
    check("t4_resumed", 64'(log_has(32'hC)), 64'(1));

    // Store into the prefetched window
    idle(20);
    dwrite(32'h14, 32'h1234_5678);
    log_q.delete();
`ifdef LT100_PF_STORE_FLUSH_EN
    fetch_chk("t5_refetch", 32'h10, 0);
    check("t5_reread_bus", 64'(log_at(0)), 64'({1'b0, 32'h10}));
    fetch_chk("t5_new_word", 32'h14, 0);
`else
    fetch_chk("t5_keep", 32'h10, 1);
    check("t5_no_reread", 64'(log_has(32'h10)), 64'(0));
`endif

    // Reset asserted while a prefetch is outstanding
    lat = 8;
    fetch_chk("t6_pre", 32'h40, 0);
    wait_bus_enable("t6_inflight");
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_bus_enable", 64'(bus_enable), 64'(0));
    check("t6_rst_if_ready", 64'(if_ready), 64'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    log_q.delete();
    lat = 2;
    fetch_chk("t6_a0", 32'h0, 0);
    check("t6_first_bus", 64'(log_at(0)), 64'({1'b0, 32'h0}));

    // Word address wraps past the top of the address space
    fetch_chk("wrap_top", 32'hFFFF_FFFC, 0);
    idle(10);
    fetch_chk("wrap_zero", 32'h0, 1);

    // Randomized mixed traffic
    pc = 32'h400;
    for (int i = 0; i < 40; i++) begin
      lat = int'($urandom_range(1, 4));
      r   = int'($urandom_range(0, 99));
      if (r < 55) begin
        fetch_chk("rnd_seq", pc, 0);
        pc += 32'h4;
      end else if (r < 70) begin
        pc = 32'h400 + ($urandom_range(0, 255) << 2);
        fetch_chk("rnd_jump", pc, 0);
        pc += 32'h4;
      end else if (r < 85) begin
        dread_chk("rnd_dread", 32'h8000 + ($urandom_range(0, 15) << 2), 0);
      end else if (r < 93) begin
        a = 32'h8000 + ($urandom_range(0, 15) << 2);
        dwrite(a, $urandom);
      end else begin
        a = 32'h9000 + ($urandom_range(0, 15) << 2);
        fork
          fetch_chk("rnd_par_if", pc, 0);
          dread_chk("rnd_par_d", a, 0);
        join
        pc += 32'h4;
      end
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 8)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lt100_prefetch.md
# lt100_prefetch

Instruction prefetch buffer and bus arbiter between the `lt100` core and `lt100_bus`. It streams sequential instruction words into a small FIFO ahead of the core's program counter and serves in-order fetches without a bus round trip. Core data loads and stores pass through to the bus with priority over prefetch. It presents two slave ports to the core (instruction, data) and one master port to `lt100_bus`.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `clk` in 1: sole clock.
- `rst_n` in 1: asynchronous active-low reset.
- `if_en` in 1: instruction fetch request; held until `if_ready`.
- `if_addr` in 32: fetch address; bits [1:0] ignored.
- `if_ready` out 1: one-cycle pulse; `if_data`/`if_err` valid.
- `if_data` out 32: instruction word.
- `if_err` out 1: the word came from a bus error.
- `d_en`, `d_wr_en` in 1: data request and direction; `d_en` held until `d_ready`.
- `d_addr` in 32, `d_wdata` in 32, `d_be` in 4: data access.
- `d_ready` out 1, `d_rdata` out 32, `d_err` out 1: data completion pulse, read data and bus error.
- `bus_enable`, `bus_wr_en` out 1; `bus_addr`, `bus_i_data` out 32; `bus_be` out 4: master side to `lt100_bus`.
- `bus_ready` in 1, `bus_o_data` in 32, `bus_err` in 1: bus response.

## Operation
- FIFO entry: {word address [31:2], data, err}. `pf_addr` is the next word to prefetch. Word addresses wrap modulo 2^32.
- **Hit:** `if_en` is high and the FIFO is non-empty with head address == `if_addr[31:2]`. The block pops the head and pulses `if_ready` with the head's data and err.
- **Miss:** `if_en` is high and the FIFO is empty or the head address differs. The block flushes the FIFO and sets `pf_addr` = `if_addr`. Any in-flight prefetch response is discarded through a drop flag. The request is held and completes as a hit once the word arrives.
- **Prefetch:** the block issues a 32-bit read (`be`=1111) at `pf_addr` when all of the following hold:
  - state is IDLE;
  - the FIFO is not full;
  - `d_en` is low;
  - no error entry is pending.
  
  On `bus_ready` it pushes {addr, `bus_o_data`, `bus_err`} and advances `pf_addr` by 4. An error entry halts prefetch until the next flush.
- **Data:** `d_en` is granted in IDLE ahead of prefetch. The bus fields are copied from the `d_*` inputs. On `bus_ready`, `d_rdata` = `bus_o_data` and `d_err` = `bus_err`, and the block pulses `d_ready`.
- FSM states:
  - IDLE: grant the data request, otherwise issue a prefetch.
  - PF_WAIT: on `bus_ready`, push the entry unless dropped.
  - D_WAIT: on `bus_ready`, pulse `d_ready`.
  - GAP: one cycle with `bus_enable` low, then back to IDLE.
- Transitions: IDLE→PF_WAIT or D_WAIT; PF_WAIT/D_WAIT→GAP on `bus_ready`; GAP→IDLE.

## Timing
- Reset clears FIFO pointers, `pf_addr`, state (to IDLE) and all outputs (to 0) immediately, including mid-transaction.
- Master handshake: `bus_*` fields are registered and held stable while `bus_enable`=1. `bus_enable` drops in the cycle after `bus_ready` is sampled (the GAP cycle).
- Hit latency: `if_ready` is high in the cycle after `if_en` is first sampled. After any `*_ready` pulse the corresponding `*_en` is ignored for one cycle, because the core drops enable one cycle late.
- Miss latency: bus latency + 3 cycles minimum.
- Data latency: bus latency + 1 cycle when IDLE. If a prefetch is in flight, that prefetch completes first, then GAP, then the data access.
- Hit and data grant may occur in the same cycle; they are independent.
- Push and pop in the same cycle on a full FIFO are legal; the count is unchanged.

## Configuration
- `LT100_PF_STORE_FLUSH_EN`:
  - Defined: a granted store (`d_wr_en`=1) flushes the FIFO, drops any in-flight prefetch, and reloads `pf_addr` from the FIFO head address. If the FIFO is empty, `pf_addr` is left unchanged. This keeps self-modifying code coherent.
  - Undefined: stores never touch the FIFO.

## Structure
- Package `lt100_pkg`: FSM state encoding and the bus be constant `BE_WORD`=4'b1111.
- One sub-module: `lt100_pf_fifo`, a synchronous FIFO with flush, push/pop, head peek, full and empty.

## Test plan
- After reset, `if_en` at 0x0 with a 2-cycle bus → `if_ready` with mem[0]. Then 0x4 and 0x8 → each hits with `if_ready` 1 cycle after `if_en`.
- FIFO full (DEPTH=4) at 0x10–0x1C, then `if_addr`=0x100 → flush; first bus read is 0x100; `if_data` = mem[0x100].
- Prefetch read in flight, then `d_en` read at 0x2000 → prefetch completes, GAP, then the bus read at 0x2000; `d_rdata` correct; no FIFO corruption.
- Prefetch at 0x8 returns `bus_err`=1 → a fetch at 0x8 gives `if_ready` with `if_err`=1; no bus read at 0xC until a miss flushes.
- With the macro defined, a store to 0x14 while the FIFO holds 0x10–0x1C → the FIFO empties; the next fetch at 0x10 rereads the bus.
- `rst_n` low in PF_WAIT → `bus_enable`=0 in the same cycle; after release, the first prefetch address is 0x0 once `if_en` at 0x0 is requested.
